// File: rtl/uart_rx_cfg_if.sv
// uart_rx_cfg_if
//   Bundle between the async serial pin, the UART receiver and the byte-stream
//   consumer. The receiver uses the master modport; the consumer (and
//   whatever drives the pin) uses the slave modport.
//   i_rx          serial input, idle high
//   o_data        last received data word (DATA_BITS wide)
//   o_valid       one-cycle pulse per completed frame
//   o_parity_err  parity mismatch for the frame in o_data
//   o_frame_err   a stop bit was sampled low
//   o_break       all data/parity bits low together with a framing error
//   o_busy        receiver is inside a frame
interface uart_rx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic                 i_rx;
  logic [DATA_BITS-1:0] o_data;
  logic                 o_valid;
  logic                 o_parity_err;
  logic                 o_frame_err;
  logic                 o_break;
  logic                 o_busy;

  modport master (
    input  i_rx,
    output o_data, o_valid, o_parity_err, o_frame_err, o_break, o_busy
  );

  modport slave (
    output i_rx,
    input  o_data, o_valid, o_parity_err, o_frame_err, o_break, o_busy
  );
endinterface

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg
//   Parametrised UART receiver: DATA_BITS data bits LSB first, optional
//   even/odd parity, one or two stop bits. Each bit is decided by a 3-sample
//   majority vote around the bit centre, so a single-cycle glitch is ignored
//   and a too-short start pulse sends the receiver back to idle.
//   Ports:
//     i_clk    clock
//     i_reset  synchronous, active-high reset
//     bus      uart_rx_cfg_if master: i_rx in, data/valid/flags/busy out
module uart_rx_cfg #(
  parameter int CLK_PER_BIT = 5208,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic          i_clk,
  input  logic          i_reset,
  uart_rx_cfg_if.master bus
);

  localparam int M     = CLK_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLK_PER_BIT);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_V0   = CNT_W'(M - 1);
  localparam logic [CNT_W-1:0] CNT_V1   = CNT_W'(M);
  localparam logic [CNT_W-1:0] CNT_DEC  = CNT_W'(M + 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic             ODD_PAR   = (PARITY_MODE == 2);
  localparam logic             HAS_PAR   = (PARITY_MODE != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_rxS;
  logic [CNT_W-1:0]       r_cnt;
  logic [3:0]             r_bitCnt;
  logic                   r_vote0;
  logic                   r_vote1;
  logic                   w_bit;
  logic                   w_cntLast;
  logic                   w_cntDec;
  logic                   w_endFrame;
  logic                   w_busy;
  logic                   w_frameErr;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_parBit;
  logic                   r_parErrP;
  logic                   r_frameErrP;
  logic [DATA_BITS-1:0]   r_data;
  logic                   r_valid;
  logic                   r_parityErr;
  logic                   r_frameErr;
  logic                   r_break;

  // Synchroniser resets to the idle level so reset never looks like a start.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_sync <= '1;
    else         r_sync <= {r_sync[SYNC_STAGES-2:0], bus.i_rx};
  end

  assign w_rxS     = r_sync[SYNC_STAGES-1];
  assign w_cntLast = (r_cnt == CNT_LAST);
  assign w_cntDec  = (r_cnt == CNT_DEC);
  // Third vote is the live sample at the decision point.
  assign w_bit     = (r_vote0 & r_vote1) | (r_vote0 & w_rxS) | (r_vote1 & w_rxS);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic. The last stop bit ends at its decision point so that
  // the following start edge is always caught.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (!w_rxS) w_next = S_START;
      S_START: begin
        if (w_cntDec && w_bit) w_next = S_IDLE;
        else if (w_cntLast)    w_next = S_DATA;
      end
      S_DATA:   if (w_cntLast && (r_bitCnt == DATA_LAST))
                  w_next = HAS_PAR ? S_PARITY : S_STOP;
      S_PARITY: if (w_cntLast) w_next = S_STOP;
      S_STOP:   if (w_cntDec && (r_bitCnt == STOP_LAST)) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Output/strobe decode.
  always_comb begin
    w_busy     = (r_state != S_IDLE);
    w_endFrame = (r_state == S_STOP) && w_cntDec && (r_bitCnt == STOP_LAST);
    w_frameErr = r_frameErrP | ~w_bit;
  end

  // Datapath: bit timer, votes, shift register, pending flags and the
  // registered results presented with o_valid.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt       <= '0;
      r_bitCnt    <= '0;
      r_vote0     <= 1'b0;
      r_vote1     <= 1'b0;
      r_shift     <= '0;
      r_parBit    <= 1'b0;
      r_parErrP   <= 1'b0;
      r_frameErrP <= 1'b0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_parityErr <= 1'b0;
      r_frameErr  <= 1'b0;
      r_break     <= 1'b0;
    end else begin
      r_valid <= 1'b0;

      if (r_state == S_IDLE || w_cntLast) r_cnt <= '0;
      else                                r_cnt <= r_cnt + 1'b1;

      if (r_state != w_next) r_bitCnt <= '0;
      else if (w_cntLast)    r_bitCnt <= r_bitCnt + 1'b1;

      if (r_cnt == CNT_V0) r_vote0 <= w_rxS;
      if (r_cnt == CNT_V1) r_vote1 <= w_rxS;

      case (r_state)
        S_IDLE: begin
          if (w_next == S_START) begin
            r_parBit    <= 1'b0;
            r_parErrP   <= 1'b0;
            r_frameErrP <= 1'b0;
          end
        end
        S_DATA: begin
          if (w_cntDec) r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
        end
        S_PARITY: begin
          if (w_cntDec) begin
            r_parBit  <= w_bit;
            r_parErrP <= (^r_shift) ^ w_bit ^ ODD_PAR;
          end
        end
        S_STOP: begin
          if (w_cntDec && !w_bit) r_frameErrP <= 1'b1;
          if (w_endFrame) begin
            r_valid     <= 1'b1;
            r_data      <= r_shift;
            r_parityErr <= r_parErrP;
            r_frameErr  <= w_frameErr;
            r_break     <= (r_shift == '0) && !r_parBit && w_frameErr;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_data       = r_data;
  assign bus.o_valid      = r_valid;
  assign bus.o_parity_err = r_parityErr;
  assign bus.o_frame_err  = r_frameErr;
  assign bus.o_break      = r_break;
  assign bus.o_busy       = w_busy;

endmodule
